izh_step_sequencer: RTL
=======================

# izh_step_sequencer

Steps a bank of Izhikevich neurons through one simulation timestep by time-multiplexing a single `izhikevich` update core. It owns the per-neuron v/u state and input-current registers and streams one neuron per cycle into the core. It writes the core's registered v'/u' results back to state and emits a spike event stream and bitmap for the downstream spike-routing logic. The a/b/c/d coefficients are wired to the core from the global configuration block, not through this block.

## Interface
- `N_NEURONS`, 16: number of neurons; legal range 2..2^ADDR_W.
- `ADDR_W`, 4: neuron index width.
- `V_INIT`, 17'h1_4100: reset value of every v entry (-65.0).
- `U_INIT`, 17'h1_0D00: reset value of every u entry (-13.0).
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request one timestep; honoured only in IDLE.
- `busy` output 1: high while a step is in progress.
- `done` output 1: one-cycle pulse when the step's last writeback completes.
- `step_count` output 16: completed steps, wraps 16'hFFFF→0.
- `i_wr_en`, `i_wr_addr`[ADDR_W], `i_wr_data`[17] inputs: host write of a neuron's input current.
- `v_out`, `u_out`, `i_out` output 17 each: to core v/u/i inputs.
- `v_in`, `u_in` input 17 each: from core v_prime/u_prime.
- `fired_in` input 1: from core fired.
- `spike_valid` output 1, `spike_id` output ADDR_W: spike event, one per fired neuron.
- `spike_vec` output N_NEURONS: bit k set if neuron k fired this step.

## Operation
- All values use 17-bit sign-magnitude: bit 16 is the sign, bits 15:8 the integer part, bits 7:0 the fraction. The block does no arithmetic on them; it only stores and forwards.
- FSM states:
  - IDLE: `start`=1 → ISSUE. Set issue_ptr=0 and clear spike_vec.
  - ISSUE: issue_ptr increments each cycle. At issue_ptr=N_NEURONS-1 → DRAIN.
  - DRAIN: one cycle for the final writeback → IDLE.
- `v_out`/`u_out`/`i_out` are combinational reads of entry issue_ptr, valid in every state. The core runs every cycle; results outside the writeback window are ignored.
- Writeback stage: the neuron issued in cycle t has its result on `v_in`/`u_in`/`fired_in` in cycle t+1. That result is written to entry wb_ptr (= previous issue_ptr) at the end of cycle t+1.
- When `fired_in`=1 at a writeback edge:
  - `spike_valid` is registered high for one cycle with `spike_id`=wb_ptr.
  - `spike_vec`[wb_ptr] is set.
- No RAW hazard: each neuron is issued exactly once per step.
- Host `i` writes are accepted in any state; the register update is at the clock edge. A write on the same cycle the target neuron is issued does not affect that issue; it applies from the next step. Out-of-range i_wr_addr writes are dropped.
- `start` while busy is ignored. `start` held high re-launches in the cycle after `done`.
- `rst` mid-step: immediately IDLE. All v=V_INIT, u=U_INIT, i=0, spike_vec=0, step_count=0; no `done` pulse.

## Timing
- Reset values:
  - busy=0, done=0, spike_valid=0, spike_id=0, spike_vec=0, step_count=0.
  - issue_ptr=0, so v_out=V_INIT, u_out=U_INIT, i_out=0.
- Edge E0 samples `start` → busy=1. Neuron k is presented after E(k) and written back at E(k+2).
- At E(N_NEURONS+1): busy=0, done=1 for one cycle, step_count increments. The last spike event is visible in the same cycle as `done`.
- Step length: N_NEURONS+1 cycles busy; minimum start-to-start period N_NEURONS+2 cycles.

## Configuration
- `IZH_CURRENT_AUTOCLEAR_EN` defined: each i entry is cleared to 0 at the edge ending its issue cycle, so current is consumed once per step. A host write to the same entry on that edge wins and persists.
- Not defined: i entries hold until rewritten by the host.

## Test plan
- Reset check: assert `rst` mid-ISSUE with N_NEURONS=16 → all outputs at reset values the same cycle. v_out=17'h1_4100, u_out=17'h1_0D00. No `done` pulse follows.
- Normal step with a stub core returning v_in=v+1.0, u_in=u, fired_in=0 → `done` 17 cycles after `start` and step_count=1. All v entries read back 17'h1_4000 (-64.0); no spike_valid.
- Stub core asserts fired_in for neurons 3 and 9 → spike_valid with spike_id=3 at E5 and spike_id=9 at E11. spike_vec=16'h0208; spike_vec clears on the next accepted `start`.
- Host writes i[5]=17'h0_0A00 during IDLE → i_out=17'h0_0A00 in the cycle after E5. With the macro defined, i[5]=0 at the next step. Without it, i[5] still reads 17'h0_0A00.
- Same-cycle write: i_wr_addr=7 in the cycle neuron 7 is issued → core sees the old value this step and the new value next step, under both configurations.
- `start` held high for 3 steps → done pulses 18 cycles apart; step_count=3; start pulses while busy are ignored. Counter wrap: preload 16'hFFFF → 0 after one step.

Source files
------------

// File: rtl/izh_step_sequencer.sv
// Time-multiplexes one Izhikevich update core over a bank of neurons: owns v/u/i state,
// issues one neuron per cycle, writes back results, emits spikes. Option: IZH_CURRENT_AUTOCLEAR_EN.
module izh_step_sequencer #(
  parameter int          N_NEURONS = 16,
  parameter int          ADDR_W    = 4,
  parameter logic [16:0] V_INIT    = 17'h1_4100,
  parameter logic [16:0] U_INIT    = 17'h1_0D00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          step_count,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [16:0]          i_wr_data,
  output logic [16:0]          v_out,
  output logic [16:0]          u_out,
  output logic [16:0]          i_out,
  input  logic [16:0]          v_in,
  input  logic [16:0]          u_in,
  input  logic                 fired_in,
  output logic                 spike_valid,
  output logic [ADDR_W-1:0]    spike_id,
  output logic [N_NEURONS-1:0] spike_vec
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_NEURONS - 1);

  logic [1:0]           state_q, state_d;
  logic [ADDR_W-1:0]    issue_ptr_q, issue_ptr_d;
  logic [ADDR_W-1:0]    wb_ptr_q;
  logic                 wb_vld_q;
  logic                 start_acc;
  logic                 done_q;
  logic [15:0]          step_count_q;
  logic                 spike_valid_q;
  logic [ADDR_W-1:0]    spike_id_q;
  logic [N_NEURONS-1:0] spike_vec_q;
  logic [16:0]          v_q [N_NEURONS];
  logic [16:0]          u_q [N_NEURONS];
  logic [16:0]          i_q [N_NEURONS];
  logic                 wr_ok;

  always_comb begin
    state_d     = state_q;
    issue_ptr_d = issue_ptr_q;
    start_acc   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_ISSUE;
        issue_ptr_d = '0;
        start_acc   = 1'b1;
      end
      S_ISSUE: begin
        issue_ptr_d = issue_ptr_q + 1'b1;
        if (issue_ptr_q == LAST) begin
          state_d     = S_DRAIN;
          issue_ptr_d = '0;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: begin
        state_d     = S_IDLE;
        issue_ptr_d = '0;
      end
    endcase
  end

  assign wr_ok = i_wr_en && (32'(i_wr_addr) < N_NEURONS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      issue_ptr_q   <= '0;
      wb_ptr_q      <= '0;
      wb_vld_q      <= 1'b0;
      done_q        <= 1'b0;
      step_count_q  <= '0;
      spike_valid_q <= 1'b0;
      spike_id_q    <= '0;
      spike_vec_q   <= '0;
      for (int n = 0; n < N_NEURONS; n++) begin
        v_q[n] <= V_INIT;
        u_q[n] <= U_INIT;
        i_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      issue_ptr_q <= issue_ptr_d;
      // Core result for the neuron issued last cycle lands this cycle.
      wb_vld_q    <= (state_q == S_ISSUE);
      wb_ptr_q    <= issue_ptr_q;
      done_q      <= (state_q == S_DRAIN);
      if (state_q == S_DRAIN) step_count_q <= step_count_q + 16'd1;
      spike_valid_q <= wb_vld_q && fired_in;
      if (start_acc) spike_vec_q <= '0;
      if (wb_vld_q) begin
        v_q[wb_ptr_q] <= v_in;
        u_q[wb_ptr_q] <= u_in;
        if (fired_in) begin
          spike_id_q            <= wb_ptr_q;
          spike_vec_q[wb_ptr_q] <= 1'b1;
        end
      end
`ifdef IZH_CURRENT_AUTOCLEAR_EN
      if (state_q == S_ISSUE) i_q[issue_ptr_q] <= '0;
`endif
      // Host write comes last so it wins over autoclear on the same entry.
      if (wr_ok) i_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign step_count  = step_count_q;
  assign spike_valid = spike_valid_q;
  assign spike_id    = spike_id_q;
  assign spike_vec   = spike_vec_q;
  assign v_out       = v_q[issue_ptr_q];
  assign u_out       = u_q[issue_ptr_q];
  assign i_out       = i_q[issue_ptr_q];

endmodule
